// File: rtl/eth_pkg.sv
// Shared definitions for the Galapagos Ethernet TX path: bus widths,
// ethertype, TX FSM states and a 64-bit byte-reverse helper.
package eth_pkg;

  localparam int ETH_W  = 64;
  localparam int KEEP_W = 8;
  localparam logic [15:0] ETHERTYPE_GALAPAGOS = 16'h7400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR0    = 2'd1,
    ST_HDR1    = 2'd2,
    ST_PAYLOAD = 2'd3
  } tx_state_e;

  // Swaps byte order so a big-endian field ends up with its MSB in
  // tdata[7:0], which is the first byte on the wire.
  function automatic logic [ETH_W-1:0] byte_rev64(input logic [ETH_W-1:0] w);
    logic [ETH_W-1:0] r;
    r = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      r[8*i +: 8] = w[ETH_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Bundles for the TX arbiter: a 64-bit AXI-Stream link and the
// request/grant link between the packet FSM and the round-robin arbiter.
//
// Handshake rule for the stream: a beat transfers on a rising clock edge
// where tvalid and tready are both 1; once tvalid is 1 the source holds
// tdata/tkeep/tlast stable and keeps tvalid high until that transfer, and
// tready may change freely.
interface eth_axis_if;
  import eth_pkg::*;

  logic [ETH_W-1:0]  tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface rr_arb_if #(parameter int N = 4);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          advance;
  logic [IW-1:0] adv_idx;

  modport master (output req, advance, adv_idx, input grant, grant_idx);
  modport slave  (input req, advance, adv_idx, output grant, grant_idx);
endinterface

// File: rtl/eth_tx_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the requester after
// the pointer; the pointer only moves on an advance strobe, so the
// winner is chosen per packet rather than per cycle.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  rr_arb_if.slave arb
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;

  // Combinational search starting at ptr_q+1, wrapping modulo N.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    arb.grant     = '0;
    arb.grant_idx = '0;
    found         = 1'b0;
    idx           = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (!found && arb.req[idx]) begin
        found          = 1'b1;
        arb.grant[idx] = 1'b1;
        arb.grant_idx  = idx;
      end
    end
  end

  // Pointer starts at N-1 so requester 0 has first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else if (arb.advance) begin
      ptr_q <= arb.adv_idx;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one 64-bit AXI-Stream Ethernet TX port between N_REQ requesters.
// Whole packets are granted round-robin and each gets a 2-flit Galapagos
// header (dst MAC, src MAC, ethertype, dest rank, src rank) in front of
// its payload. Destination MACs come from a software-written rank table.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter int          RANK_W    = 4,
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_GALAPAGOS
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_REQ*ETH_W-1:0]  s_tdata,
  input  logic [N_REQ*KEEP_W-1:0] s_tkeep,
  input  logic [N_REQ-1:0]        s_tlast,
  input  logic [N_REQ*8-1:0]      s_tdest,
  input  logic [N_REQ-1:0]        s_tvalid,
  output logic [N_REQ-1:0]        s_tready,
  output logic [ETH_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]       m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  input  logic [47:0]             src_mac,
  input  logic [7:0]              src_rank,
  input  logic                    mac_wr_en,
  input  logic [RANK_W-1:0]       mac_wr_addr,
  input  logic [47:0]             mac_wr_data,
  output tx_state_e               dbg_state_o
);

  localparam int GW    = $clog2(N_REQ);
  localparam int TBL_N = 1 << RANK_W;

  logic [ETH_W-1:0]  req_data [N_REQ];
  logic [KEEP_W-1:0] req_keep [N_REQ];
  logic [7:0]        req_dest [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_data[g] = s_tdata[g*ETH_W +: ETH_W];
    assign req_keep[g] = s_tkeep[g*KEEP_W +: KEEP_W];
    assign req_dest[g] = s_tdest[g*8 +: 8];
  end

  tx_state_e        state_q;
  logic [GW-1:0]    grant_q;
  logic [ETH_W-1:0] hdr0_q;
  logic [ETH_W-1:0] hdr1_q;
  logic [47:0]      mac_tbl_q [TBL_N];

  logic [7:0]  win_dest;
  logic [47:0] win_dmac;
  logic        pay_done;

  rr_arb_if #(.N(N_REQ)) arb_bus ();
  eth_axis_if            tx_bus ();

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk (aclk),
    .rst (areset),
    .arb (arb_bus.slave)
  );

  assign arb_bus.req     = s_tvalid;
  assign arb_bus.advance = pay_done;
  assign arb_bus.adv_idx = grant_q;

  // The lookup reads the current table contents, so a write landing in the
  // same cycle as the grant is not seen by that packet.
  assign win_dest = req_dest[arb_bus.grant_idx];
  assign win_dmac = mac_tbl_q[win_dest[RANK_W-1:0]];

  assign pay_done = (state_q == ST_PAYLOAD) && s_tvalid[grant_q] &&
                    m_tready && s_tlast[grant_q];

  // Packet FSM plus MAC table; both header words are frozen at grant time
  // so later table writes or src field changes never touch an in-flight header.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      hdr0_q  <= '0;
      hdr1_q  <= '0;
      for (int i = 0; i < TBL_N; i++) begin
        mac_tbl_q[i] <= '0;
      end
    end else begin
      if (mac_wr_en) begin
        mac_tbl_q[mac_wr_addr] <= mac_wr_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (arb_bus.grant != '0) begin
            grant_q <= arb_bus.grant_idx;
            hdr0_q  <= byte_rev64({win_dmac, src_mac[47:32]});
            hdr1_q  <= byte_rev64({src_mac[31:0], ETHERTYPE, win_dest, src_rank});
            state_q <= ST_HDR0;
          end
        end
        ST_HDR0: if (m_tready) state_q <= ST_HDR1;
        ST_HDR1: if (m_tready) state_q <= ST_PAYLOAD;
        ST_PAYLOAD: if (pay_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output mux: headers from registers, payload passed straight through
  // from the granted requester with its tready tied to the MAC's.
  always_comb begin
    tx_bus.tdata  = '0;
    tx_bus.tkeep  = '0;
    tx_bus.tlast  = 1'b0;
    tx_bus.tvalid = 1'b0;
    s_tready      = '0;
    case (state_q)
      ST_HDR0: begin
        tx_bus.tdata  = hdr0_q;
        tx_bus.tkeep  = '1;
        tx_bus.tvalid = 1'b1;
      end
      ST_HDR1: begin
        tx_bus.tdata  = hdr1_q;
        tx_bus.tkeep  = '1;
        tx_bus.tvalid = 1'b1;
      end
      ST_PAYLOAD: begin
        tx_bus.tdata      = req_data[grant_q];
        tx_bus.tkeep      = req_keep[grant_q];
        tx_bus.tlast      = s_tlast[grant_q];
        tx_bus.tvalid     = s_tvalid[grant_q];
        s_tready[grant_q] = m_tready;
      end
      default: ;
    endcase
  end

  assign tx_bus.tready = m_tready;
  assign m_tdata       = tx_bus.tdata;
  assign m_tkeep       = tx_bus.tkeep;
  assign m_tlast       = tx_bus.tlast;
  assign m_tvalid      = tx_bus.tvalid;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: single-packet header check, round-robin
// order, backpressure, table write races, mid-packet reset and requester stall.
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [N*64-1:0] s_tdata;
  logic [N*8-1:0]  s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N*8-1:0]  s_tdest;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [47:0]     src_mac;
  logic [7:0]      src_rank;
  logic            mac_wr_en;
  logic [3:0]      mac_wr_addr;
  logic [47:0]     mac_wr_data;
  tx_state_e       dbg_state;

  eth_axis_if tx_if ();

  eth_tx_arbiter #(.N_REQ(N), .RANK_W(4), .ETHERTYPE(16'h7400)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .s_tdest     (s_tdest),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (tx_if.tdata),
    .m_tkeep     (tx_if.tkeep),
    .m_tlast     (tx_if.tlast),
    .m_tvalid    (tx_if.tvalid),
    .m_tready    (tx_if.tready),
    .src_mac     (src_mac),
    .src_rank    (src_rank),
    .mac_wr_en   (mac_wr_en),
    .mac_wr_addr (mac_wr_addr),
    .mac_wr_data (mac_wr_data),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [80:0] src_q [N][$];   // {dest, last, keep, data}
  logic [72:0] exp_q [$];      // {last, keep, data}
  logic [N-1:0] hold;
  int           pop_cnt [N];
  logic         ready_mode;
  logic [47:0]  tbl_m [16];
  int           checks;
  int           errors;
  logic         prev_stall;
  logic [72:0]  prev_flit;

  task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Header words built byte by byte in wire order.
  function automatic logic [63:0] hdr0_w(input logic [47:0] dmac);
    logic [63:0] w;
    logic [47:0] smac;
    smac = src_mac;
    for (int k = 0; k < 6; k++) w[8*k +: 8] = dmac[47-8*k -: 8];
    w[55:48] = smac[47:40];
    w[63:56] = smac[39:32];
    return w;
  endfunction

  function automatic logic [63:0] hdr1_w(input logic [7:0] dest);
    logic [63:0] w;
    logic [47:0] smac;
    smac = src_mac;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = smac[31-8*k -: 8];
    w[39:32] = 8'h74;
    w[47:40] = 8'h00;
    w[55:48] = dest;
    w[63:56] = src_rank;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    logic [80:0] e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        s_tvalid[i]        = !hold[i];
        s_tdata[i*64 +: 64] = e[63:0];
        s_tkeep[i*8 +: 8]  = e[71:64];
        s_tlast[i]         = e[72];
        s_tdest[i*8 +: 8]  = e[80:73];
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*64 +: 64] = '0;
        s_tkeep[i*8 +: 8]  = '0;
        s_tlast[i]         = 1'b0;
        s_tdest[i*8 +: 8]  = '0;
      end
    end
    tx_if.tready = ready_mode ? ~tx_if.tready : 1'b1;
  endtask

  task automatic monitor();
    logic [72:0] flit;
    flit = {tx_if.tlast, tx_if.tkeep, tx_if.tdata};
    chk("hs_rule", 81'({(|(s_tvalid & s_tready)) && !tx_if.tready,
                       ($countones(s_tready) > 1)}), 81'd0);
    if (prev_stall) chk("hold_stable", {7'd0, tx_if.tvalid, flit}, {7'd0, 1'b1, prev_flit});
    if (tx_if.tvalid && tx_if.tready) begin
      if (exp_q.size() == 0) chk("unexpected_flit", 81'(exp_q.size()), 81'd1);
      else chk("tx_flit", {8'd0, flit}, {8'd0, exp_q.pop_front()});
    end
    prev_stall = tx_if.tvalid && !tx_if.tready && !areset;
    prev_flit  = flit;
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        void'(src_q[i].pop_front());
        pop_cnt[i]++;
      end
    end
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    mac_wr_en = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] addr, input logic [47:0] data);
    mac_wr_en   = 1'b1;
    mac_wr_addr = addr;
    mac_wr_data = data;
    tbl_m[addr] = data;
  endtask

  task automatic send_pkt(input int req, input logic [7:0] dest, input int n,
                          input logic [7:0] lkeep, input logic [7:0] tag);
    logic [63:0] d;
    logic [7:0]  kp;
    logic        lst;
    exp_q.push_back({1'b0, 8'hff, hdr0_w(tbl_m[dest[3:0]])});
    exp_q.push_back({1'b0, 8'hff, hdr1_w(dest)});
    for (int k = 0; k < n; k++) begin
      d   = {8'(req), tag, 40'h0, 8'(k)};
      lst = (k == n - 1);
      kp  = lst ? lkeep : 8'hff;
      src_q[req].push_back({dest, lst, kp, d});
      exp_q.push_back({lst, kp, d});
    end
  endtask

  function automatic int src_pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic wait_pop(input int req, input int target, input string tag);
    int n;
    n = 0;
    while (pop_cnt[req] < target && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 81'(pop_cnt[req] >= target), 81'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_pending() != 0) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 81'(exp_q.size()), 81'd0);
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) tbl_m[i] = '0;
    hold       = '0;
    prev_stall = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {3'd0, tx_if.tvalid, tx_if.tlast, tx_if.tkeep, tx_if.tdata, s_tready}, 81'd0);
    chk({tag, "_state"}, 81'(dbg_state), 81'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b;
    checks = 0; errors = 0;
    areset = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tdest = '0; s_tvalid = '0;
    src_mac = 48'hfa163e55ca02; src_rank = 8'h01;
    mac_wr_en = 1'b0; mac_wr_addr = '0; mac_wr_data = '0;
    ready_mode = 1'b0; tx_if.tready = 1'b1;
    for (int i = 0; i < N; i++) pop_cnt[i] = 0;
    flush_model();
    @(posedge aclk); #1;
    tick(); tick();
    check_reset_outputs("reset");
    areset = 1'b0;

    // Single requester, literal header values.
    set_wr(4'd3, 48'h0cc47a88c047);
    tick();
    src_q[0].push_back({8'd3, 1'b0, 8'hff, 64'h0100000100030000});
    src_q[0].push_back({8'd3, 1'b1, 8'h0f, 64'h5073930200000000});
    exp_q.push_back({1'b0, 8'hff, 64'h16fa47c0887ac40c});
    exp_q.push_back({1'b0, 8'hff, 64'h0103007402ca553e});
    exp_q.push_back({1'b0, 8'hff, 64'h0100000100030000});
    exp_q.push_back({1'b1, 8'h0f, 64'h5073930200000000});
    tick();
    chk("latency_hdr0", 81'({tx_if.tvalid, dbg_state}), 81'({1'b1, ST_HDR0}));
    drain("basic_drain");

    // Round-robin from reset: expected order 0,1,2,3,0.
    areset = 1'b1; tick(); tick(); areset = 1'b0; flush_model();
    for (int i = 1; i <= 4; i++) begin
      set_wr(4'(i), {40'h02_0000_0000, 8'(i)} | 48'h0a0000000000);
      tick();
    end
    for (int i = 0; i < N; i++) send_pkt(i, 8'(i + 1), 2, 8'h3f, 8'h01);
    send_pkt(0, 8'd1, 2, 8'hff, 8'h02);
    drain("rr_drain");

    // Backpressure with tready toggling.
    ready_mode = 1'b1;
    send_pkt(1, 8'd2, 3, 8'h07, 8'h03);
    send_pkt(2, 8'd3, 3, 8'hff, 8'h03);
    drain("bp_drain");
    ready_mode = 1'b0;

    // Table write mid-packet, then write racing a grant in IDLE.
    b = pop_cnt[0];
    send_pkt(0, 8'd3, 4, 8'hff, 8'h04);
    wait_pop(0, b + 1, "race_wait");
    set_wr(4'd3, 48'h02aabbccdd03);
    tick();
    drain("race_old_drain");
    send_pkt(0, 8'd3, 2, 8'hff, 8'h05);
    drain("race_new_drain");
    send_pkt(0, 8'd3, 2, 8'h0f, 8'h06);
    set_wr(4'd3, 48'h02deadbeef04);
    drain("same_cycle_drain");
    send_pkt(0, 8'd3, 1, 8'h01, 8'h07);
    drain("single_flit_drain");

    // Reset on the 2nd payload flit.
    b = pop_cnt[0];
    send_pkt(0, 8'd3, 3, 8'hff, 8'h08);
    wait_pop(0, b + 1, "rst_wait");
    areset = 1'b1;
    tick();
    areset = 1'b0;
    flush_model();
    check_reset_outputs("midpkt_reset");
    send_pkt(0, 8'd3, 2, 8'hff, 8'h09);
    send_pkt(1, 8'd2, 2, 8'hff, 8'h09);
    drain("post_reset_drain");

    // Requester 2 stalls mid-packet while requester 1 waits.
    b = pop_cnt[2];
    send_pkt(2, 8'd2, 4, 8'hff, 8'h0a);
    wait_pop(2, b + 1, "stall_wait");
    send_pkt(1, 8'd1, 2, 8'hff, 8'h0a);
    hold[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_idle", 81'({tx_if.tvalid, dbg_state}), 81'({1'b0, ST_PAYLOAD}));
    end
    hold[2] = 1'b0;
    drain("stall_drain");

    // ---------------- report ----------------
    chk("final_queue", 81'(exp_q.size()), 81'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
